// File: rtl/instr_encoder_pkg.sv
// Shared RV32I field types and constants for the instruction encoder slice.
package instr_encoder_pkg;

    typedef logic [31:0] data_t;
    typedef logic [4:0]  reg_addr_t;
    typedef logic [2:0]  funct3_t;
    typedef logic [6:0]  funct7_t;

    typedef enum logic [6:0] {
        LOAD           = 7'b0000011,
        ARITHMETIC_IMM = 7'b0010011,
        AUIPC          = 7'b0010111,
        STORE          = 7'b0100011,
        ARITHMETIC_REG = 7'b0110011,
        LUI            = 7'b0110111,
        BRANCH         = 7'b1100011,
        JALR           = 7'b1100111,
        JAL            = 7'b1101111
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_BAD
    } imm_sel_t;

    typedef enum logic [1:0] {
        StIdle, StRun, StDone
    } enc_state_t;

    localparam data_t NOP_INSN = 32'h0000_0013;

    function automatic imm_sel_t imm_sel_of(opcode_t op);
        imm_sel_t sel;
        case (op)
            ARITHMETIC_REG:              sel = IMM_R;
            LOAD, ARITHMETIC_IMM, JALR:  sel = IMM_I;
            STORE:                       sel = IMM_S;
            BRANCH:                      sel = IMM_B;
            LUI, AUIPC:                  sel = IMM_U;
            JAL:                         sel = IMM_J;
            default:                     sel = IMM_BAD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational inverse of ImmGen: packs decoded fields into an RV32I word.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  opcode_t   i_op,
    input  reg_addr_t i_rd,
    input  funct3_t   i_funct3,
    input  funct7_t   i_funct7,
    input  reg_addr_t i_rs1,
    input  reg_addr_t i_rs2,
    input  data_t     i_imm,
    input  imm_sel_t  i_imm_sel,
    output data_t     o_word,
    output logic      o_unenc
);

    always_comb begin
        o_word  = NOP_INSN;
        o_unenc = 1'b0;
        case (i_imm_sel)
            IMM_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_op};
            IMM_I: begin
                o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
                o_unenc = (i_imm != {{20{i_imm[11]}}, i_imm[11:0]});
            end
            IMM_S: begin
                o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_op};
                o_unenc = (i_imm != {{20{i_imm[11]}}, i_imm[11:0]});
            end
            IMM_B: begin
                o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_op};
                o_unenc = (i_imm != {{19{i_imm[12]}}, i_imm[12:0]}) || i_imm[0];
            end
            IMM_U: begin
                o_word  = {i_imm[31:12], i_rd, i_op};
                o_unenc = (i_imm[11:0] != 12'h000);
            end
            IMM_J: begin
                o_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_op};
                o_unenc = (i_imm != {{11{i_imm[20]}}, i_imm[20:0]}) || i_imm[0];
            end
            default: o_unenc = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded RV32I words into IMEM at consecutive addresses, with
// one registered write stage, run-control FSM and sticky error capture.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  opcode_t           op_i,
    input  reg_addr_t         rd_i,
    input  funct3_t           funct3_i,
    input  funct7_t           funct7_i,
    input  reg_addr_t         rs1_i,
    input  reg_addr_t         rs2_i,
    input  data_t             imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output data_t             mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    enc_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  r_to_accept;
    logic              r_we;
    data_t             r_wdata;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;

    data_t             w_word;
    logic              w_unenc;
    logic              w_hs;
    logic              w_accept;
    logic [ADDR_W-1:0] w_bundle_addr;

    instr_pack u_pack (
        .i_op      (op_i),
        .i_rd      (rd_i),
        .i_funct3  (funct3_i),
        .i_funct7  (funct7_i),
        .i_rs1     (rs1_i),
        .i_rs2     (rs2_i),
        .i_imm     (imm_i),
        .i_imm_sel (imm_sel_of(op_i)),
        .o_word    (w_word),
        .o_unenc   (w_unenc)
    );

    assign w_hs       = r_we && mem_ready_i;
    assign in_ready_o = (r_state == StRun) && (r_to_accept != '0) && (!r_we || mem_ready_i);
    assign w_accept   = in_valid_i && in_ready_o;
    // A bundle accepted alongside a retiring write lands one word further on.
    assign w_bundle_addr = w_hs ? r_addr + ADDR_W'(4) : r_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_remaining <= '0;
            r_to_accept <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_addr      <= {start_addr_i[ADDR_W-1:2], 2'b00};
                        r_remaining <= count_i;
                        r_to_accept <= count_i;
                        r_err       <= 1'b0;
                        r_err_addr  <= '0;
                        r_state     <= (count_i == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (w_hs) begin
                        r_addr      <= r_addr + ADDR_W'(4);
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= StDone;
                        end
                    end
                    if (w_accept) begin
                        r_we        <= 1'b1;
                        r_wdata     <= w_unenc ? NOP_INSN : w_word;
                        r_to_accept <= r_to_accept - CNT_W'(1);
                        if (w_unenc) begin
                            r_err <= 1'b1;
                            if (!r_err) begin
                                r_err_addr <= w_bundle_addr;
                            end
                        end
                    end else if (w_hs) begin
                        r_we <= 1'b0;
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign busy_o      = (r_state != StIdle);
    assign done_o      = (r_state == StDone);
    assign err_o       = r_err;
    assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// runs compared against an arithmetic reference encoder.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CNT_W  = 9;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W-1:0] start_addr_i;
    logic [CNT_W-1:0]  count_i;
    logic              in_valid_i;
    logic              in_ready_o;
    opcode_t           op_i;
    reg_addr_t         rd_i;
    funct3_t           funct3_i;
    funct7_t           funct7_i;
    reg_addr_t         rs1_i;
    reg_addr_t         rs2_i;
    data_t             imm_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    data_t             mem_wdata_o;
    logic              mem_ready_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [ADDR_W-1:0] err_addr_o;

    instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .count_i      (count_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .op_i         (op_i),
        .rd_i         (rd_i),
        .funct3_i     (funct3_i),
        .funct7_i     (funct7_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .imm_i        (imm_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ready_i  (mem_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_addr_o   (err_addr_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_acc_cyc = 0;
    int last_done_cyc = 0;
    bundle_t prog[$];
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (mem_we_o && mem_ready_i) begin
                wr_addr.push_back(mem_addr_o);
                wr_data.push_back(mem_wdata_o);
            end
            if (done_o) begin
                done_cnt = done_cnt + 1;
                last_done_cyc = cyc;
            end
            if (in_valid_i && in_ready_o) last_acc_cyc = cyc;
        end
    end

    // Reference encoder: returns {unencodable, word}.
    function automatic logic [32:0] ref_enc(bundle_t b);
        longint s;
        logic [31:0] u;
        logic [31:0] w;
        bit bad;
        s = longint'($signed(b.imm));
        u = b.imm;
        w = 32'h0;
        bad = 1'b0;
        case (b.op)
            7'h33: w = (32'(b.f7) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
                     | (32'(b.f3) << 12) | (32'(b.rd) << 7) | 32'(b.op);
            7'h13, 7'h03, 7'h67: begin
                bad = (s < -2048) || (s > 2047);
                w = ((u & 32'hFFF) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
                  | (32'(b.rd) << 7) | 32'(b.op);
            end
            7'h23: begin
                bad = (s < -2048) || (s > 2047);
                w = (((u >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
                  | (32'(b.f3) << 12) | ((u & 32'h1F) << 7) | 32'(b.op);
            end
            7'h63: begin
                bad = (s < -4096) || (s > 4095) || (u % 2 != 0);
                w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                  | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
                  | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'(b.op);
            end
            7'h37, 7'h17: begin
                bad = (u % 4096) != 0;
                w = (u & 32'hFFFF_F000) | (32'(b.rd) << 7) | 32'(b.op);
            end
            7'h6F: begin
                bad = (s < -1048576) || (s > 1048575) || (u % 2 != 0);
                w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                  | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
                  | (32'(b.rd) << 7) | 32'(b.op);
            end
            default: bad = 1'b1;
        endcase
        if (bad) w = 32'h0000_0013;
        return {bad, w};
    endfunction

    function automatic logic [ADDR_W-1:0] ref_addr(logic [ADDR_W-1:0] sa, int i);
        return ADDR_W'(((int'(sa) / 4) * 4 + 4 * i) % 1024);
    endfunction

    function automatic bundle_t mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                   logic [4:0] rs2, logic [2:0] f3, logic [31:0] imm);
        bundle_t b;
        b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = 7'h00; b.imm = imm;
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        logic [6:0] ops [9];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        r = $urandom;
        b.op  = ($urandom_range(11) == 0) ? 7'h7F : ops[$urandom_range(8)];
        b.rd  = 5'($urandom);
        b.rs1 = 5'($urandom);
        b.rs2 = 5'($urandom);
        b.f3  = 3'($urandom);
        b.f7  = 7'($urandom);
        case ($urandom_range(3))
            0:       b.imm = {{20{r[11]}}, r[11:0]};
            1:       b.imm = {{19{r[12]}}, r[12:1], 1'b0};
            2:       b.imm = {{11{r[20]}}, r[20:1], 1'b0};
            default: b.imm = ($urandom_range(1) == 0) ? (r & 32'hFFFF_F000) : r;
        endcase
        return b;
    endfunction

    task automatic drive_bundle(bundle_t b);
        op_i = opcode_t'(b.op);
        rd_i = b.rd; rs1_i = b.rs1; rs2_i = b.rs2;
        funct3_i = b.f3; funct7_i = b.f7; imm_i = b.imm;
    endtask

    // Runs prog from IDLE; called and returns at posedge+1.
    task automatic run_prog(input logic [ADDR_W-1:0] sa, input int ready_pct,
                            input int valid_pct, input bit poke_start,
                            output int stalls, output bit timed_out);
        int idx;
        int n;
        int d0;
        wr_addr.delete();
        wr_data.delete();
        d0 = done_cnt;
        start_i = 1'b1;
        start_addr_i = sa;
        count_i = CNT_W'(prog.size());
        @(posedge clk); #1;
        start_i = 1'b0;
        idx = 0; n = 0; stalls = 0;
        while (done_cnt == d0 && n < 2000) begin
            mem_ready_i = ($urandom_range(99) < ready_pct);
            if (poke_start) begin
                start_i = 1'($urandom_range(1));
                count_i = CNT_W'($urandom);
                start_addr_i = ADDR_W'($urandom);
            end
            if (idx < prog.size() && $urandom_range(99) < valid_pct) begin
                in_valid_i = 1'b1;
                drive_bundle(prog[idx]);
            end else begin
                in_valid_i = 1'b0;
                drive_bundle(rand_bundle());
            end
            @(negedge clk);
            if (idx < prog.size() && busy_o && !in_ready_o) stalls++;
            if (in_valid_i && in_ready_o) idx++;
            @(posedge clk); #1;
            n++;
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
        mem_ready_i = 1'b1;
        timed_out = (done_cnt == d0);
    endtask

    task automatic test_reset();
        n_cmp++; if (mem_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", mem_we_o); end
        n_cmp++; if (mem_wdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", mem_wdata_o); end
        n_cmp++; if (mem_addr_o !== '0) begin n_bad++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
        n_cmp++; if ({busy_o, done_o, in_ready_o} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl got %b want 000", {busy_o, done_o, in_ready_o}); end
        n_cmp++; if ({err_o, err_addr_o} !== '0) begin n_bad++; $display("FAIL reset_err got %b/%h want 0/0", err_o, err_addr_o); end
    endtask

    task automatic test_single();
        int st; bit to;
        prog.delete();
        prog.push_back(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5));
        run_prog(10'h000, 100, 100, 1'b0, st, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL single_timeout got no done want done"); end
        n_cmp++; if (wr_data.size() != 1) begin n_bad++; $display("FAIL single_nwrites got %0d want 1", wr_data.size()); end
        else begin
            n_cmp++; if (wr_addr[0] !== 10'h000 || wr_data[0] !== 32'h0050_0093) begin
                n_bad++; $display("FAIL single_write got %h@%h want 00500093@000", wr_data[0], wr_addr[0]);
            end
        end
        n_cmp++; if (last_done_cyc - last_acc_cyc != 2) begin n_bad++; $display("FAIL single_done_lat got %0d want 2", last_done_cyc - last_acc_cyc); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL single_err got %b want 0", err_o); end
    endtask

    task automatic test_back_to_back();
        int st; bit to;
        logic [31:0] exp_d [3];
        exp_d = '{32'h0020_A423, 32'h0080_00EF, 32'h1234_52B7};
        prog.delete();
        prog.push_back(mk(7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8));
        prog.push_back(mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'b000, 32'd8));
        prog.push_back(mk(7'h37, 5'd5, 5'd0, 5'd0, 3'b000, 32'h1234_5000));
        run_prog(10'h010, 100, 100, 1'b0, st, to);
        n_cmp++; if (to || wr_data.size() != 3) begin n_bad++; $display("FAIL b2b_nwrites got %0d want 3", wr_data.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (wr_data[i] !== exp_d[i] || wr_addr[i] !== ref_addr(10'h010, i)) begin
                    n_bad++; $display("FAIL b2b_write%0d got %h@%h want %h@%h", i, wr_data[i], wr_addr[i], exp_d[i], ref_addr(10'h010, i));
                end
            end
        end
        n_cmp++; if (st != 0) begin n_bad++; $display("FAIL b2b_ready got %0d stall cycles want 0", st); end
    endtask

    task automatic test_backpressure();
        int n; int d0;
        wr_addr.delete(); wr_data.delete();
        d0 = done_cnt;
        mem_ready_i = 1'b0;
        start_i = 1'b1; start_addr_i = 10'h040; count_i = 9'd2;
        @(posedge clk); #1;
        start_i = 1'b0;
        in_valid_i = 1'b1;
        drive_bundle(mk(7'h63, 5'd0, 5'd0, 5'd0, 3'b000, 32'hFFFF_FFFC));
        @(negedge clk);
        n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_first_ready got %b want 1", in_ready_o); end
        @(posedge clk); #1;
        drive_bundle(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5));
        for (int k = 0; k < 4; k++) begin
            mem_ready_i = (k == 3);
            @(negedge clk);
            n_cmp++;
            if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'hFE00_0EE3 || mem_addr_o !== 10'h040) begin
                n_bad++; $display("FAIL bp_hold%0d got we=%b %h@%h want we=1 fe000ee3@040", k, mem_we_o, mem_wdata_o, mem_addr_o);
            end
            n_cmp++;
            if (in_ready_o !== (k == 3)) begin n_bad++; $display("FAIL bp_ready%0d got %b want %b", k, in_ready_o, k == 3); end
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 50) begin @(posedge clk); #1; n++; end
        n_cmp++; if (done_cnt == d0) begin n_bad++; $display("FAIL bp_timeout got no done want done"); end
        n_cmp++;
        if (wr_data.size() != 2 || wr_addr[1] !== 10'h044 || wr_data[1] !== 32'h0050_0093) begin
            n_bad++; $display("FAIL bp_second got %0d writes want 2 ending 00500093@044", wr_data.size());
        end
    endtask

    task automatic test_error();
        int st; bit to;
        prog.delete();
        prog.push_back(mk(7'h63, 5'd0, 5'd0, 5'd0, 3'b000, 32'd3));
        prog.push_back(mk(7'h13, 5'd3, 5'd4, 5'd0, 3'b000, 32'h800));
        run_prog(10'h020, 100, 100, 1'b0, st, to);
        n_cmp++;
        if (to || wr_data.size() != 2 || wr_data[0] !== 32'h13 || wr_data[1] !== 32'h13) begin
            n_bad++; $display("FAIL err_nop got %0d writes want two 00000013", wr_data.size());
        end
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_flag got %b want 1", err_o); end
        n_cmp++; if (err_addr_o !== 10'h020) begin n_bad++; $display("FAIL err_addr got %h want 020", err_addr_o); end
    endtask

    task automatic test_wrap();
        int st; bit to;
        prog.delete();
        prog.push_back(mk(7'h13, 5'd2, 5'd0, 5'd0, 3'b000, 32'd1));
        prog.push_back(mk(7'h13, 5'd3, 5'd0, 5'd0, 3'b000, 32'd2));
        run_prog(10'h3FE, 100, 100, 1'b0, st, to);
        n_cmp++;
        if (to || wr_addr.size() != 2 || wr_addr[0] !== 10'h3FC || wr_addr[1] !== 10'h000) begin
            n_bad++; $display("FAIL wrap_addr got %0d writes want 3fc then 000", wr_addr.size());
        end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL wrap_err got %b want 0", err_o); end
    endtask

    task automatic test_random();
        int st; bit to; int cnt; logic [ADDR_W-1:0] sa;
        logic [32:0] e; bit exp_err; logic [ADDR_W-1:0] exp_ea;
        for (int run = 0; run < 8; run++) begin
            prog.delete();
            cnt = $urandom_range(12, 1);
            for (int i = 0; i < cnt; i++) prog.push_back(rand_bundle());
            sa = ADDR_W'($urandom);
            run_prog(sa, 60, 70, 1'b1, st, to);
            n_cmp++;
            if (to || wr_data.size() != cnt) begin
                n_bad++; $display("FAIL rand%0d_nwrites got %0d want %0d", run, wr_data.size(), cnt);
                continue;
            end
            exp_err = 1'b0; exp_ea = '0;
            for (int i = 0; i < cnt; i++) begin
                e = ref_enc(prog[i]);
                if (e[32] && !exp_err) begin exp_err = 1'b1; exp_ea = ref_addr(sa, i); end
                n_cmp++;
                if (wr_data[i] !== e[31:0] || wr_addr[i] !== ref_addr(sa, i)) begin
                    n_bad++; $display("FAIL rand%0d_write%0d got %h@%h want %h@%h", run, i, wr_data[i], wr_addr[i], e[31:0], ref_addr(sa, i));
                end
            end
            n_cmp++;
            if (err_o !== exp_err || err_addr_o !== exp_ea) begin
                n_bad++; $display("FAIL rand%0d_err got %b/%h want %b/%h", run, err_o, err_addr_o, exp_err, exp_ea);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        wr_addr.delete(); wr_data.delete();
        mem_ready_i = 1'b0;
        start_i = 1'b1; start_addr_i = 10'h100; count_i = 9'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        in_valid_i = 1'b1;
        drive_bundle(mk(7'h7F, 5'd1, 5'd1, 5'd1, 3'b000, 32'd0));
        n = 0;
        @(negedge clk);
        while (!in_ready_o && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        n_cmp++; if (mem_we_o !== 1'b1 || err_o !== 1'b1) begin n_bad++; $display("FAIL rst_pre got we=%b err=%b want 1/1", mem_we_o, err_o); end
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({mem_we_o, busy_o, err_o} !== 3'b000) begin
            n_bad++; $display("FAIL rst_async got we/busy/err=%b want 000", {mem_we_o, busy_o, err_o});
        end
        @(negedge clk); rst_i = 1'b0;
        mem_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b1; count_i = 9'd0;
        @(posedge clk); #1;
        start_i = 1'b0;
        n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL cnt0_done got %b want 1", done_o); end
        @(posedge clk); #1;
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL cnt0_idle got done=%b busy=%b want 0/0", done_o, busy_o); end
        n_cmp++; if (wr_data.size() != 0) begin n_bad++; $display("FAIL cnt0_writes got %0d want 0", wr_data.size()); end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; start_addr_i = '0; count_i = '0;
        in_valid_i = 1'b0; mem_ready_i = 1'b1;
        drive_bundle(mk(7'h13, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0));
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_i = 1'b0;
        @(posedge clk); #1;
        test_single();
        test_back_to_back();
        test_backpressure();
        test_error();
        test_wrap();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
